// File: rtl/trigger_event_logger.sv
// Timestamps rising edges of the trigger pulse with a prescaled counter and queues them
// in a small FIFO for the register map, with an event count and sticky overflow/wrap flags.
module trigger_event_logger #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_sync,
    input  logic                    trig_in,
    input  logic                    cfg_enable,
    input  logic [4:0]              cfg_prescale,
    input  logic                    clear,
    input  logic                    rd_req,
    output logic [TS_WIDTH-1:0]     rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    overflow,
    output logic                    ts_wrapped,
    output logic [CNT_WIDTH-1:0]    event_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FCW   = PTR_W + 1;

    logic [4:0]          pre_cnt;
    logic [TS_WIDTH-1:0] ts;
    logic                trig_d;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [TS_WIDTH-1:0] mem [DEPTH];

    logic [4:0]          pre_end;
    logic                tick;
    logic                trig_edge;
    logic                rd_ok;
    logic                wr_ok;
    logic                drop;
    logic                mem_we;
    logic [FCW-1:0]      count_nxt;

    // Tick, edge and FIFO handshake decode; a read on a full FIFO frees the slot for a same-cycle write.
    always_comb begin
        pre_end   = 5'd0;
        tick      = 1'b0;
        trig_edge = 1'b0;
        rd_ok     = 1'b0;
        wr_ok     = 1'b0;
        drop      = 1'b0;
        mem_we    = 1'b0;
        count_nxt = fifo_count;
        if (cfg_prescale > 5'd1)
            pre_end = cfg_prescale - 5'd1;
        // >= also recovers if the prescale is lowered mid-count
        tick      = cfg_enable && (pre_cnt >= pre_end);
        trig_edge = trig_in && !trig_d && cfg_enable;
        rd_ok     = rd_req && !fifo_empty;
        wr_ok     = trig_edge && (!fifo_full || rd_ok);
        drop      = trig_edge && fifo_full && !rd_ok;
        mem_we    = wr_ok && !clear && !rst_sync;
        count_nxt = FCW'(fifo_count + FCW'(wr_ok) - FCW'(rd_ok));
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= ts;
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pre_cnt     <= '0;
            ts          <= '0;
            trig_d      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            ts_wrapped  <= 1'b0;
            event_count <= '0;
        end else begin
            trig_d <= trig_in;
            if (clear) begin
                pre_cnt     <= '0;
                ts          <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                fifo_empty  <= 1'b1;
                fifo_full   <= 1'b0;
                rd_valid    <= 1'b0;
                overflow    <= 1'b0;
                ts_wrapped  <= 1'b0;
                event_count <= '0;
            end else begin
                if (!cfg_enable) begin
                    pre_cnt <= '0;
                    ts      <= '0;
                end else if (tick) begin
                    pre_cnt <= '0;
                    ts      <= ts + TS_WIDTH'(1);
                    if (ts == '1)
                        ts_wrapped <= 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 5'd1;
                end

                rd_valid <= rd_ok;
                if (rd_ok) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end
                if (wr_ok)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                fifo_count <= count_nxt;
                fifo_empty <= (count_nxt == '0);
                fifo_full  <= (count_nxt == FCW'(DEPTH));

                if (drop)
                    overflow <= 1'b1;
                if (trig_edge && (event_count != '1))
                    event_count <= event_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_trigger_event_logger.sv
// Directed bench for trigger_event_logger: capture, prescale, overflow, full read/write, wrap and clear.
module tb_trigger_event_logger;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned TS_WIDTH  = 8;
    localparam int unsigned CNT_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst_sync;
    logic                   trig_in;
    logic                   cfg_enable;
    logic [4:0]             cfg_prescale;
    logic                   clear;
    logic                   rd_req;
    logic [TS_WIDTH-1:0]    rd_data;
    logic                   rd_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   overflow;
    logic                   ts_wrapped;
    logic [CNT_WIDTH-1:0]   event_count;

    int n_vec  = 0;
    int n_miss = 0;

    trigger_event_logger #(
        .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_sync(rst_sync), .trig_in(trig_in), .cfg_enable(cfg_enable),
        .cfg_prescale(cfg_prescale), .clear(clear), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
        .ts_wrapped(ts_wrapped), .event_count(event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clear leaves ts at 0, so the k-th following edge captures ts = floor((k-1)/prescale).
    task automatic restart();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    // Edges at cycles 1,3,5,... after restart (prescale 0) capture 0,2,4,...
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            trig_in = 1'b1;
            step(1);
            trig_in = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst_sync = 1'b1; trig_in = 1'b0; cfg_enable = 1'b0; cfg_prescale = 5'd0;
        clear = 1'b0; rd_req = 1'b0;
        #1;
        step(2);
        rst_sync = 1'b0;
        step(1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_flags", {30'd0, overflow, ts_wrapped}, 32'd0);
        check("rst_events", 32'(event_count), 32'd0);
        check("rst_rdvalid", 32'(rd_valid), 32'd0);

        // Capture with a 10-cycle pulse at ts=25
        cfg_enable = 1'b1;
        step(25);
        trig_in = 1'b1;
        step(1);
        check("cap_count", 32'(fifo_count), 32'd1);
        check("cap_events", 32'(event_count), 32'd1);
        step(9);
        trig_in = 1'b0;
        step(1);
        check("cap_one_entry", 32'(fifo_count), 32'd1);
        check("cap_one_event", 32'(event_count), 32'd1);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        check("cap_rdvalid", 32'(rd_valid), 32'd1);
        check("cap_rddata", 32'(rd_data), 32'd25);
        check("cap_drained", 32'(fifo_count), 32'd0);
        check("cap_empty", 32'(fifo_empty), 32'd1);
        step(1);
        check("cap_rdvalid_pulse", 32'(rd_valid), 32'd0);

        // Disabled: edges ignored
        cfg_enable = 1'b0;
        pulses(2);
        check("dis_count", 32'(fifo_count), 32'd0);
        check("dis_events", 32'(event_count), 32'd1);

        // Prescale 10: edges at clocks 47 and 123
        cfg_prescale = 5'd10;
        cfg_enable   = 1'b1;
        restart();
        step(46);
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
        step(75);
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
        check("pre_count", 32'(fifo_count), 32'd2);
        rd_req = 1'b1;
        step(1);
        check("pre_first", 32'(rd_data), 32'd4);
        step(1);
        rd_req = 1'b0;
        check("pre_second", 32'(rd_data), 32'd12);
        check("pre_empty", 32'(fifo_empty), 32'd1);

        // Overflow: 17 edges, no reads
        cfg_prescale = 5'd1;
        restart();
        pulses(17);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_events", 32'(event_count), 32'd17);
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check($sformatf("ovf_rd%0d", i), 32'(rd_data), 32'(2 * i));
            check($sformatf("ovf_rv%0d", i), 32'(rd_valid), 32'd1);
        end
        step(1);
        rd_req = 1'b0;
        check("ovf_empty", 32'(fifo_empty), 32'd1);
        check("ovf_rd_ignored", 32'(rd_valid), 32'd0);
        check("ovf_rd_hold", 32'(rd_data), 32'd30);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous read and edge
        cfg_prescale = 5'd0;
        restart();
        pulses(16);
        check("fw_full", 32'(fifo_full), 32'd1);
        trig_in = 1'b1;
        rd_req  = 1'b1;
        step(1);
        trig_in = 1'b0;
        check("fw_rddata", 32'(rd_data), 32'd0);
        check("fw_count", 32'(fifo_count), 32'd16);
        check("fw_ovf", 32'(overflow), 32'd0);
        step(15);
        check("fw_rd15", 32'(rd_data), 32'd30);
        step(1);
        rd_req = 1'b0;
        check("fw_last", 32'(rd_data), 32'd32);
        check("fw_empty", 32'(fifo_empty), 32'd1);
        check("fw_events", 32'(event_count), 32'd17);

        // Wrap after 256 ticks, then clear coinciding with an edge
        restart();
        step(255);
        check("wrap_before", 32'(ts_wrapped), 32'd0);
        step(1);
        check("wrap_set", 32'(ts_wrapped), 32'd1);
        trig_in = 1'b1;
        clear   = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr_wrap", 32'(ts_wrapped), 32'd0);
        check("clr_events", 32'(event_count), 32'd0);
        check("clr_count", 32'(fifo_count), 32'd0);
        check("clr_empty", 32'(fifo_empty), 32'd1);
        step(3);
        check("clr_no_retrig", 32'(fifo_count), 32'd0);
        check("clr_no_event", 32'(event_count), 32'd0);
        trig_in = 1'b0;
        step(1);
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
        check("clr_next_edge", 32'(event_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/trigger_event_logger.md
Name: trigger_event_logger

Overview:
- Sits directly downstream of the trigger block and consumes its trigger_out pulse.
- Detects each rising edge of that pulse and timestamps it with a prescaled free-running counter.
- Stores timestamps in a small FIFO that the UART register map reads one entry at a time.
- Also keeps a saturating event count, a sticky overflow flag and a sticky timestamp-wrap flag.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of 2, at least 2.
- TS_WIDTH, 32: timestamp counter and read-data width.
- CNT_WIDTH, 16: event counter width.

Ports:
- clk, input, 1: fpga clock.
- rst_sync, input, 1: reset, synchronous and active-high.
- trig_in, input, 1: trigger_out from the trigger block. Flopped and in the clk domain; no synchronizer here.
- cfg_enable, input, 1: high enables timestamping and capture.
- cfg_prescale, input, 5: clocks per timestamp tick. Values 0 and 1 both mean every clock.
- clear, input, 1: single-cycle pulse that flushes all state.
- rd_req, input, 1: single-cycle read strobe.
- rd_data, output, TS_WIDTH: oldest timestamp, valid when rd_valid is high.
- rd_valid, output, 1: one-cycle pulse, one clock after an accepted rd_req.
- fifo_count, output, $clog2(DEPTH)+1: number of entries held, 0 to DEPTH.
- fifo_empty, output, 1: high when fifo_count == 0.
- fifo_full, output, 1: high when fifo_count == DEPTH.
- overflow, output, 1: sticky; set when an edge is dropped because the FIFO is full.
- ts_wrapped, output, 1: sticky; set when the timestamp wraps.
- event_count, output, CNT_WIDTH: saturating count of detected edges.

Behaviour:
- Reset (rst_sync high at a clk edge):
  - Every register goes to 0: timestamp, prescale counter, trig_d, FIFO pointers, rd_data, rd_valid, overflow, ts_wrapped, event_count.
  - After reset, fifo_empty=1 and fifo_full=0.
  - Reset has priority over everything else.
- Prescaler:
  - pre_end = (cfg_prescale > 1) ? cfg_prescale-1 : 0.
  - pre_cnt counts 0 up to pre_end; when pre_cnt == pre_end, tick=1 and pre_cnt returns to 0.
  - When cfg_enable=0, pre_cnt is held at 0 and tick=0.
- Timestamp (ts):
  - Increments by 1 on each tick.
  - When cfg_enable=0, ts is held at 0.
  - When ts == all-ones and tick=1, ts wraps to 0 and ts_wrapped is set.
- Edge detect:
  - trig_d <= trig_in every cycle, regardless of enable.
  - edge = trig_in & ~trig_d & cfg_enable.
  - A 10- or 100-cycle pulse produces exactly one edge.
- Capture:
  - On edge, the ts value of that same cycle (before its increment) is written to the FIFO.
  - fifo_count reflects the write on the next clock.
  - event_count increments on every edge, saturating at all-ones, including edges dropped on overflow.
- Read:
  - rd_req with fifo_empty=0: on the next clock rd_valid=1, rd_data = the oldest entry, the read pointer advances, and fifo_count decrements.
  - rd_req with fifo_empty=1: ignored. rd_valid stays 0 and rd_data holds its last value.
  - rd_valid is high for exactly one cycle per accepted read.
- Simultaneous read and write:
  - Not full, not empty: both are performed and fifo_count is unchanged.
  - Empty: the write is performed, the read is ignored, and fifo_count becomes 1.
  - Full: the read frees a slot and the write is accepted. fifo_count stays DEPTH and overflow is not set.
- Full without read: the edge is dropped, overflow is set, FIFO contents are unchanged, and event_count still increments.
- Pointers:
  - log2(DEPTH)-bit pointers that wrap naturally.
  - Full/empty are derived from fifo_count.
- clear:
  - Zeroes ts, pre_cnt, pointers, fifo_count, overflow, ts_wrapped, event_count and rd_valid.
  - Overrides any edge or rd_req in the same cycle.
  - trig_d still updates, so an edge during clear is lost and a still-high trig_in afterwards does not re-trigger.
- Disabling cfg_enable mid-operation: FIFO contents and flags are retained; only ts and pre_cnt are zeroed.

Test Plan:
1. Reset behaviour: hold rst_sync for 2 cycles, then release -> all outputs 0, fifo_empty=1; ts starts incrementing once cfg_enable=1.
2. Capture and read: cfg_prescale=0, cfg_enable=1; raise trig_in for 10 cycles when ts=25; pulse rd_req -> fifo_count=1 after the edge, exactly one entry, event_count=1; next clock rd_valid=1, rd_data=25, fifo_count=0.
3. Prescale and ordering: cfg_prescale=10; edges at clock 47 and clock 123 after enable -> entries 4 then 12, read out in that order.
4. Overflow: DEPTH=16; 17 edges with no reads -> fifo_full=1, overflow=1, event_count=17, first 16 timestamps preserved; then 16 reads return them in order and end with fifo_empty=1.
5. Full with simultaneous read and edge: FIFO full, rd_req and edge in the same cycle -> rd_data = the oldest entry, fifo_count stays 16, overflow=0, the new timestamp is read last.
6. Wrap and clear: TS_WIDTH=8, prescale 0 -> after 256 ticks ts_wrapped=1; clear pulse coinciding with an edge -> everything zero, no entry written, trig_in still high afterwards gives no capture.
